// File: rtl/decode_pkg.sv
// Shared constants for the RV32I decode queue: opcode rows, control-field codes,
// bundle bit positions and the per-entry decode result type.
package decode_pkg;

  localparam int CTRL_W = 16;

  // opcode[6:2] rows
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [2:0] IMM_I_LOAD  = 3'b000;
  localparam logic [2:0] IMM_I_ARITH = 3'b001;
  localparam logic [2:0] IMM_I_SHIFT = 3'b010;
  localparam logic [2:0] IMM_S       = 3'b011;
  localparam logic [2:0] IMM_U       = 3'b100;
  localparam logic [2:0] IMM_B       = 3'b101;
  localparam logic [2:0] IMM_JALR    = 3'b110;
  localparam logic [2:0] IMM_J       = 3'b111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_U    = 2'b10;
  localparam logic [1:0] RES_PC4  = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // control bundle bit positions, MSB first
  localparam int B_ALUOP_HI  = 15;
  localparam int B_ALUOP_LO  = 14;
  localparam int B_ALUSRC    = 13;
  localparam int B_IMM_HI    = 12;
  localparam int B_IMM_LO    = 10;
  localparam int B_RES_HI    = 9;
  localparam int B_RES_LO    = 8;
  localparam int B_REGWRITE  = 7;
  localparam int B_MEMREQ    = 6;
  localparam int B_MEMWRITE  = 5;
  localparam int B_BRANCH    = 4;
  localparam int B_JAL       = 3;
  localparam int B_JALR      = 2;
  localparam int B_IMMPLUS   = 1;
  localparam int B_LDSIGNED  = 0;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
    logic              sys;
    logic              csr;
  } decode_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch/execute handshake bundle for decode_queue; slave is the queue, master the
// surrounding pipeline.
interface decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                     i_valid;
  logic                     o_ready;
  logic [31:0]              i_instr;
  logic [XLEN-1:0]          i_pc;
  logic                     i_flush;
  logic                     o_valid;
  logic                     i_ready;
  logic [15:0]              o_ctrl;
  logic [XLEN-1:0]          o_pc;
  logic [31:0]              o_instr;
  logic                     o_illegal;
  logic                     o_sys;
  logic                     o_csr;
  logic [$clog2(DEPTH):0]   o_count;

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_ctrl, o_pc, o_instr, o_illegal, o_sys, o_csr, o_count
  );

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_ctrl, o_pc, o_instr, o_illegal, o_sys, o_csr, o_count
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I decoder: instr -> {ctrl, illegal, sys, csr}.
// Define DECODE_ZICSR_EN to decode CSR accesses; otherwise they are illegal.
module decode_logic
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [4:0]        op;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              shift_imm;
  logic [CTRL_W-1:0] ctrl;
  logic              legal;
  logic              sys;
  logic              csr;
  logic              plus_en;

  assign op        = instr[6:2];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign shift_imm = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    ctrl    = '0;
    legal   = 1'b0;
    sys     = 1'b0;
    csr     = 1'b0;
    plus_en = 1'b0;
    case (op)
      OP_LOAD: begin
        legal = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        ctrl[B_ALUSRC]            = 1'b1;
        ctrl[B_IMM_HI:B_IMM_LO]   = IMM_I_LOAD;
        ctrl[B_RES_HI:B_RES_LO]   = RES_MEM;
        ctrl[B_REGWRITE]          = 1'b1;
        ctrl[B_MEMREQ]            = 1'b1;
        ctrl[B_LDSIGNED]          = ~f3[2];
        plus_en                   = 1'b1;
      end
      OP_FENCE: legal = 1'b1;
      OP_IMM: begin
        legal = !shift_imm || (f7 == 7'b0000000) ||
                ((f3 == 3'b101) && (f7 == 7'b0100000));
        ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_FUNCT;
        ctrl[B_ALUSRC]              = 1'b1;
        ctrl[B_IMM_HI:B_IMM_LO]     = shift_imm ? IMM_I_SHIFT : IMM_I_ARITH;
        ctrl[B_REGWRITE]            = 1'b1;
        plus_en                     = 1'b1;
      end
      OP_STORE: begin
        legal = (f3 < 3'b011);
        ctrl[B_ALUSRC]          = 1'b1;
        ctrl[B_IMM_HI:B_IMM_LO] = IMM_S;
        ctrl[B_MEMREQ]          = 1'b1;
        ctrl[B_MEMWRITE]        = 1'b1;
        plus_en                 = 1'b1;
      end
      OP_OP: begin
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_FUNCT;
        ctrl[B_REGWRITE]            = 1'b1;
        plus_en                     = 1'b1;
      end
      OP_AUIPC, OP_LUI: begin
        legal = 1'b1;
        ctrl[B_IMM_HI:B_IMM_LO] = IMM_U;
        ctrl[B_RES_HI:B_RES_LO] = RES_U;
        ctrl[B_REGWRITE]        = 1'b1;
        plus_en                 = 1'b1;
      end
      OP_BRANCH: begin
        legal = !((f3 == 3'b010) || (f3 == 3'b011));
        ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_BR;
        ctrl[B_IMM_HI:B_IMM_LO]     = IMM_B;
        ctrl[B_BRANCH]              = 1'b1;
        plus_en                     = 1'b1;
      end
      OP_JALR: begin
        legal = (f3 == 3'b000);
        ctrl[B_ALUSRC]          = 1'b1;
        ctrl[B_IMM_HI:B_IMM_LO] = IMM_JALR;
        ctrl[B_RES_HI:B_RES_LO] = RES_PC4;
        ctrl[B_REGWRITE]        = 1'b1;
        ctrl[B_JALR]            = 1'b1;
        plus_en                 = 1'b1;
      end
      OP_JAL: begin
        legal = 1'b1;
        ctrl[B_IMM_HI:B_IMM_LO] = IMM_J;
        ctrl[B_RES_HI:B_RES_LO] = RES_PC4;
        ctrl[B_REGWRITE]        = 1'b1;
        ctrl[B_JAL]             = 1'b1;
        plus_en                 = 1'b1;
      end
      OP_SYSTEM: begin
        // only the exact ECALL/EBREAK words are accepted in the funct3=000 space
        if (f3 == 3'b000) begin
          legal = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
          sys   = legal;
        end
`ifdef DECODE_ZICSR_EN
        else if (f3 != 3'b100) begin
          legal            = 1'b1;
          csr              = 1'b1;
          ctrl[B_ALUSRC]   = 1'b1;
          ctrl[B_REGWRITE] = 1'b1;
        end
`endif
      end
      default: legal = 1'b0;
    endcase
    if (plus_en) ctrl[B_IMMPLUS] = ~instr[5];
    if (instr[1:0] != 2'b11) legal = 1'b0;

    dec.ctrl    = legal ? ctrl : '0;
    dec.illegal = ~legal;
    dec.sys     = legal & sys;
    dec.csr     = legal & csr;
  end

endmodule

// File: rtl/decode_queue.sv
// Registered RV32I decode stage: decodes on entry and buffers results in a
// DEPTH-entry FIFO toward execute, with valid/ready backpressure and flush.
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  decode_queue_if.slave  dq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decode_t         dec_mem   [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  decode_t       in_dec;

  decode_logic u_dec (
    .instr (dq.i_instr),
    .dec   (in_dec)
  );

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = dq.i_valid && !full && !dq.i_flush;
  assign pop   = !empty && dq.i_ready && !dq.i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (dq.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // power-of-two depth: pointers wrap by natural overflow
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      dec_mem[wr_ptr]   <= in_dec;
      pc_mem[wr_ptr]    <= dq.i_pc;
      instr_mem[wr_ptr] <= dq.i_instr;
    end
  end

  // storage is not reset, so head fields are forced to zero while empty
  assign dq.o_valid   = !empty;
  assign dq.o_ready   = !full;
  assign dq.o_count   = count;
  assign dq.o_ctrl    = empty ? '0 : dec_mem[rd_ptr].ctrl;
  assign dq.o_illegal = empty ? 1'b0 : dec_mem[rd_ptr].illegal;
  assign dq.o_sys     = empty ? 1'b0 : dec_mem[rd_ptr].sys;
  assign dq.o_csr     = empty ? 1'b0 : dec_mem[rd_ptr].csr;
  assign dq.o_pc      = empty ? '0 : pc_mem[rd_ptr];
  assign dq.o_instr   = empty ? '0 : instr_mem[rd_ptr];

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: randomized traffic on a DEPTH=4 queue
// against a queue-based model, plus directed cases on a DEPTH=2 queue.
// Honors DECODE_ZICSR_EN for CSR expectations.
module tb_decode_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_queue_if #(.XLEN(32), .DEPTH(4)) qa ();
  decode_queue_if #(.XLEN(32), .DEPTH(2)) qb ();

  decode_queue #(.XLEN(32), .DEPTH(4)) u_dut_a (.i_clk(clk), .i_rst(rst), .dq(qa.slave));
  decode_queue #(.XLEN(32), .DEPTH(2)) u_dut_b (.i_clk(clk), .i_rst(rst), .dq(qb.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] aop, input logic asrc,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic br, input logic jl, input logic jr,
                                     input logic ip, input logic ls);
    return {aop, asrc, imm, res, rw, mr, mw, br, jl, jr, ip, ls};
  endfunction

  // reference decode from the opcode row table: returns {ctrl, illegal, sys, csr}
  function automatic logic [18:0] ref_dec(input logic [31:0] w);
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ip;
    logic        ok;
    logic        s;
    logic        cs;
    logic        sh;
    logic [15:0] c;
    op = w[6:2]; f3 = w[14:12]; f7 = w[31:25]; ip = ~w[5];
    ok = 1'b1; s = 1'b0; cs = 1'b0; c = 16'h0;
    sh = (f3 == 3'd1) || (f3 == 3'd5);
    case (op)
      5'b00000: begin
        ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        c  = mk(2'b00, 1'b1, 3'b000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ip, ~f3[2]);
      end
      5'b00100: begin
        ok = !sh || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
        c  = mk(2'b10, 1'b1, sh ? 3'b010 : 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ip, 1'b0);
      end
      5'b01000: begin
        ok = f3 < 3'd3;
        c  = mk(2'b00, 1'b1, 3'b011, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ip, 1'b0);
      end
      5'b01100: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        c  = mk(2'b10, 1'b0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ip, 1'b0);
      end
      5'b00101, 5'b01101:
        c = mk(2'b00, 1'b0, 3'b100, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ip, 1'b0);
      5'b11000: begin
        ok = !(f3 == 3'd2 || f3 == 3'd3);
        c  = mk(2'b01, 1'b0, 3'b101, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ip, 1'b0);
      end
      5'b11001: begin
        ok = f3 == 3'd0;
        c  = mk(2'b00, 1'b1, 3'b110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ip, 1'b0);
      end
      5'b11011:
        c = mk(2'b00, 1'b0, 3'b111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ip, 1'b0);
      5'b00011: c = 16'h0;
      5'b11100: begin
        if (f3 == 3'd0) begin
          ok = (w == 32'h0000_0073) || (w == 32'h0010_0073);
          s  = ok;
        end else begin
`ifdef DECODE_ZICSR_EN
          ok = f3 != 3'd4;
          cs = ok;
          c  = mk(2'b00, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
          ok = 1'b0;
`endif
        end
      end
      default: ok = 1'b0;
    endcase
    if (w[1:0] != 2'b11) ok = 1'b0;
    if (!ok) return {16'h0, 1'b1, 1'b0, 1'b0};
    return {c, 1'b0, s, cs};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 14);
    case (k)
      0:  r[6:0] = 7'h03;
      1:  r[6:0] = 7'h13;
      2:  r[6:0] = 7'h23;
      3:  r[6:0] = 7'h33;
      4:  r[6:0] = 7'h37;
      5:  r[6:0] = 7'h17;
      6:  r[6:0] = 7'h63;
      7:  r[6:0] = 7'h67;
      8:  r[6:0] = 7'h6F;
      9:  r[6:0] = 7'h0F;
      10: r[6:0] = 7'h73;
      11: r = 32'h0000_0073;
      12: r = 32'h0010_0073;
      13: r = 32'h3000_2573;
      default: ;
    endcase
    if ((k == 1 || k == 3) && $urandom_range(0, 2) != 0)
      r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return r;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  task automatic check_a();
    logic [18:0] d;
    chk("a_valid", qa.o_valid, mq.size() > 0);
    chk("a_ready", qa.o_ready, mq.size() < 4);
    chk("a_count", qa.o_count, mq.size());
    if (mq.size() > 0) begin
      d = ref_dec(mq[0].instr);
      chk("a_ctrl",    qa.o_ctrl,    d[18:3]);
      chk("a_illegal", qa.o_illegal, d[2]);
      chk("a_sys",     qa.o_sys,     d[1]);
      chk("a_csr",     qa.o_csr,     d[0]);
      chk("a_pc",      qa.o_pc,      mq[0].pc);
      chk("a_instr",   qa.o_instr,   mq[0].instr);
    end else begin
      chk("a_empty_ctrl", {qa.o_ctrl, qa.o_illegal, qa.o_sys, qa.o_csr}, 0);
      chk("a_empty_pc",   {qa.o_pc, qa.o_instr}, 0);
    end
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
    qb.i_valid = v; qb.i_instr = ins; qb.i_pc = pc; qb.i_ready = rdy; qb.i_flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] ill_v [5] = '{32'h0000_B003, 32'h0000_0010, 32'h0200_0033,
                             32'h0000_0073, 32'h3000_2573};

  localparam logic [31:0] ADDI = 32'h00A0_0093;
  localparam logic [31:0] LW   = 32'h0000_A103;
  localparam logic [31:0] SW   = 32'h0020_A223;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        psh;
    logic        pp;
    logic [31:0] pc_ctr;
    logic [18:0] d;
    qa.i_valid = 1'b0; qa.i_instr = '0; qa.i_pc = '0; qa.i_flush = 1'b0; qa.i_ready = 1'b0;
    qb.i_valid = 1'b0; qb.i_instr = '0; qb.i_pc = '0; qb.i_flush = 1'b0; qb.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", qa.o_valid, 0);
    chk("rst_ready", qa.o_ready, 1);
    chk("rst_count", qa.o_count, 0);
    chk("rst_ctrl",  qa.o_ctrl,  0);

    // three pushes into the DEPTH=4 queue, then an asynchronous reset mid-cycle
    qa.i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      qa.i_instr = ADDI; qa.i_pc = 32'h40 + 32'(4 * i);
      @(negedge clk);
    end
    qa.i_valid = 1'b0;
    chk("pre_rst_count", qa.o_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", qa.o_valid, 0);
    chk("arst_count", qa.o_count, 0);
    chk("arst_ready", qa.o_ready, 1);
    chk("arst_ctrl",  qa.o_ctrl,  0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the queue model
    pc_ctr = 32'h1000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      check_a();
      qa.i_valid = ($urandom_range(0, 3) != 0);
      qa.i_ready = (cyc % 100 < 30) ? 1'b0 : ($urandom_range(0, 2) != 0);
      qa.i_flush = ($urandom_range(0, 40) == 0);
      qa.i_instr = rand_instr();
      qa.i_pc    = pc_ctr;
      psh = qa.i_valid && (mq.size() < 4) && !qa.i_flush;
      pp  = (mq.size() > 0) && qa.i_ready && !qa.i_flush;
      if (qa.i_flush) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (psh) mq.push_back('{instr: qa.i_instr, pc: pc_ctr});
      end
      if (psh) pc_ctr = pc_ctr + 4;
    end
    qa.i_valid = 1'b0; qa.i_flush = 1'b0;

    // fill DEPTH=2, hold the third instruction, then drain in order
    drive_b(1'b1, ADDI, 32'h100, 1'b0, 1'b0);
    chk("b_lat_count", qb.o_count, 1);
    chk("b_lat_pc",    qb.o_pc, 32'h100);
    drive_b(1'b1, LW, 32'h104, 1'b0, 1'b0);
    chk("b_full_count", qb.o_count, 2);
    chk("b_full_ready", qb.o_ready, 0);
    chk("b_addi_ctrl",  qb.o_ctrl, 16'b10_1_001_00_1_0_0_0_0_0_1_0);
    chk("b_addi_pc",    qb.o_pc, 32'h100);
    drive_b(1'b1, SW, 32'h108, 1'b0, 1'b0);
    chk("b_hold_count", qb.o_count, 2);
    chk("b_hold_pc",    qb.o_pc, 32'h100);
    drive_b(1'b1, SW, 32'h108, 1'b1, 1'b0);
    chk("b_pop1_count", qb.o_count, 1);
    chk("b_lw_ctrl",    qb.o_ctrl, 16'b00_1_000_01_1_1_0_0_0_0_1_1);
    chk("b_lw_pc",      qb.o_pc, 32'h104);
    chk("b_pop1_ready", qb.o_ready, 1);
    drive_b(1'b1, SW, 32'h108, 1'b1, 1'b0);
    d = ref_dec(SW);
    chk("b_sw_count", qb.o_count, 1);
    chk("b_sw_pc",    qb.o_pc, 32'h108);
    chk("b_sw_ctrl",  qb.o_ctrl, d[18:3]);
    drive_b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("b_drain_valid", qb.o_valid, 0);

    // back-to-back stream of illegal / system words at one per cycle
    for (int i = 0; i < 5; i++) begin
      drive_b(1'b1, ill_v[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      d = ref_dec(ill_v[i]);
      chk("s_count",   qb.o_count, 1);
      chk("s_instr",   qb.o_instr, ill_v[i]);
      chk("s_ctrl",    qb.o_ctrl, d[18:3]);
      chk("s_illegal", qb.o_illegal, d[2]);
      chk("s_sys",     qb.o_sys, d[1]);
      chk("s_csr",     qb.o_csr, d[0]);
      if (i < 3) begin
        chk("ill_flag", qb.o_illegal, 1);
        chk("ill_ctrl", qb.o_ctrl, 0);
      end
      if (i == 3) chk("ecall_sys", qb.o_sys, 1);
      if (i == 4) begin
`ifdef DECODE_ZICSR_EN
        chk("csrrs_csr", qb.o_csr, 1);
`else
        chk("csrrs_ill", qb.o_illegal, 1);
`endif
      end
    end
    drive_b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("s_drain_count", qb.o_count, 0);

    // flush with full queue and a valid input in the same cycle
    drive_b(1'b1, ADDI, 32'h300, 1'b0, 1'b0);
    drive_b(1'b1, LW,   32'h304, 1'b0, 1'b0);
    chk("f_pre_count", qb.o_count, 2);
    drive_b(1'b1, SW, 32'h308, 1'b1, 1'b1);
    chk("f_count", qb.o_count, 0);
    chk("f_valid", qb.o_valid, 0);
    chk("f_ready", qb.o_ready, 1);
    chk("f_ctrl",  qb.o_ctrl, 0);
    drive_b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("f_after_count", qb.o_count, 0);
    chk("f_after_valid", qb.o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered RV32I decode stage sitting between fetch and execute.
- Accepts raw instructions with PC over a valid/ready handshake.
- Decodes each into a fixed control bundle, full legality checking included, and buffers the results in a DEPTH-entry FIFO feeding execute.
- Successor to the combinational main decoder:
  - don't-cares are replaced by defined zeros;
  - adds fence/system/illegal decode, buffering, backpressure and flush.

Parameters:
- XLEN, 32, width of PC field.
- DEPTH, 2, FIFO entries; power of two, >=2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  fetch offers instruction.
- o_ready  out  1  queue can accept; equals !full (no combinational path from i_ready).
- i_instr  in  32  raw instruction.
- i_pc  in  XLEN  instruction address.
- i_flush  in  1  discard all queued entries and the current input.
- o_valid  out  1  head entry valid (!empty).
- i_ready  in  1  execute consumes head.
- o_ctrl  out  CTRL_W  head control bundle.
- o_pc  out  XLEN  head PC.
- o_instr  out  32  head instruction (immediate/funct extraction downstream).
- o_illegal  out  1  head is illegal instruction.
- o_sys  out  1  head is ECALL/EBREAK.
- o_csr  out  1  head is CSR access.
- o_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async, any time including mid-transfer): rd/wr pointers 0, count 0, o_valid 0, o_ready 1, all head outputs 0. Storage contents need no reset; outputs are gated to 0 when empty.
- Push when i_valid && o_ready && !i_flush; pop when o_valid && i_ready && !i_flush. Simultaneous push+pop: count unchanged; legal when full only via pop freeing a slot next cycle, never same cycle.
- Latency: accepted instruction is visible at head no earlier than the cycle after acceptance. Sustained 1/cycle throughput when i_ready held high.
- i_flush: next cycle count=0, pointers equal; input in the flush cycle is dropped; no pop occurs.
- Pointers wrap modulo DEPTH.
- Decode is combinational on i_instr, and the result is stored with the entry.
- Bundle order MSB->LSB: ALUOp[1:0], ALUSrc, immSrc[2:0], resultSrc[1:0], regWrite, memReq, memWrite, branch, jal, jalr, immPlusSrc, isLoadSigned (CTRL_W=16).
- immSrc codes: 000 I-load, 001 I-arith, 010 I-shift, 011 S, 100 U, 101 B, 110 JALR, 111 J.
- resultSrc codes: 00 ALU, 01 mem, 10 U-result, 11 PC+4.
- ALUOp codes: 00 add, 01 branch compare, 10 funct-decoded.
- immPlusSrc = ~instr[5]; isLoadSigned = ~funct3[2] (1 = sign-extend LB/LH/LW).
- Opcode[6:2] rows: 00000 load, 00100 op-imm, 01000 store, 01100 op, 0?101 LUI/AUIPC, 11000 branch, 11001 JALR, 11011 JAL.
  - Field values identical to the existing main decoder, with every unused field forced to 0.
  - 00011 FENCE: legal NOP, all enables 0.
- Illegal when any of:
  - instr[1:0]!=11;
  - unlisted opcode;
  - load funct3 in {011,110,111};
  - store funct3>=011;
  - branch funct3 in {010,011};
  - JALR funct3!=000;
  - op funct7 not 0000000 (or 0100000 for funct3 000/101);
  - shift-imm funct7 not 0000000 (or 0100000 for SRAI).
- Illegal entries: whole o_ctrl=0, o_illegal=1, o_sys=0, o_csr=0.
- System opcode 11100, funct3=000, instr==0x00000073 or 0x00100073: o_sys=1, ctrl=0. Other funct3=000 encodings are illegal.

Optional Feature:
- DECODE_ZICSR_EN defined: system opcode with funct3 in {001,010,011,101,110,111} decodes as CSR. o_csr=1, regWrite=1, resultSrc=00, ALUSrc=1, other fields 0. funct3=100 is illegal.
- Not defined: all system encodings other than ECALL/EBREAK are illegal; o_csr is tied 0.

Decomposition:
- Package decode_pkg holds:
  - CTRL_W;
  - opcode[6:2] localparams;
  - immSrc, resultSrc and ALUOp code constants;
  - bundle field bit positions.
- Sub-module decode_logic: the combinational instr -> {ctrl, illegal, sys, csr} decoder.
- decode_queue owns the FIFO, handshake and flush.

Test Plan:
- Reset mid-stream: 3 pushes with DEPTH=4, assert i_rst -> o_valid=0, o_count=0, o_ready=1, o_ctrl=0 immediately (asynchronous).
- Push 0x00A00093 (ADDI), pc=0x100, then 0x0000A103 (LW) -> head ctrl=16'b10_1_001_00_1_0_0_0_0_0_1_0 pc=0x100; after pop, ctrl=16'b00_1_000_01_1_1_0_0_0_0_1_1.
- Fill DEPTH=2 with i_ready=0 -> o_ready=0 on cycle 2, third instr held by fetch. Then i_ready=1 with i_valid=1 -> one pop per cycle and FIFO order preserved.
- Illegal: 0x0000B003 (LD funct3=011), 0x00000013 with bits[1:0]=00, 0x02000033 (MUL) -> each o_illegal=1, o_ctrl=0.
- Flush with count=2 plus i_valid=1 in same cycle -> next cycle count=0, o_valid=0; flushed input never appears.
- 0x00000073 -> o_sys=1. 0x30002573 (CSRRS) -> o_csr=1 with DECODE_ZICSR_EN, o_illegal=1 without.
